aud_fir_arbiter: RTL
====================

AUD_FIR_ARBITER -- requirements
Module: aud_fir_arbiter

Interface
REQ-001 Parameter OBUF_DEPTH, default 4, per-channel result buffer depth; power of two, at least 2.
REQ-002 Parameter IN_MSB, default 31, top bit of the 16-bit slice [IN_MSB:IN_MSB-15] taken from 32-bit input samples; range 15..31.
REQ-003 Port clk_clk  in  1  sole clock, all logic on its rising edge.
REQ-004 Port reset_reset  in  1  reset, synchronous and active-high.
REQ-005 Ports left_in_data/right_in_data  in  32  Avalon-ST sink samples per channel.
REQ-006 Ports left_in_valid/right_in_valid  in  1; left_in_ready/right_in_ready  out  1  sink handshake.
REQ-007 Ports fir_in_data  out  16; fir_in_valid  out  1; fir_in_error  out  2  feed to the shared FIR.
REQ-008 Ports fir_out_data  in  32; fir_out_valid  in  1; fir_out_error  in  2  FIR result, no backpressure.
REQ-009 Ports left_out_data/right_out_data  out  32; *_out_valid  out  1; *_out_ready  in  1  Avalon-ST source per channel.
REQ-010 Port orphan_err  out  1  sticky: FIR result arrived with no outstanding tag.
REQ-011 Port fir_err  out  1  sticky FIR error flag (see Configuration).

Function
REQ-012 Transfer occurs on a channel when valid and ready are both high in the same cycle.
REQ-013 Credit(ch) = OBUF_DEPTH - buffer occupancy(ch) - in-flight(ch); a channel is eligible only when credit is above 0.
REQ-014 in_ready(ch) = eligible(ch) AND (rr_ptr = ch OR other channel not valid OR other channel not eligible); it does not depend on its own valid.
REQ-015 At most one input transfer per cycle; rr_ptr toggles to the other channel after each transfer and holds otherwise; reset value is left.
REQ-016 Issue latency is 1 cycle: fir_in_data <= accepted sample slice, fir_in_valid <= 1, fir_in_error constant 0; fir_in_valid = 0 in cycles with no transfer.
REQ-017 Each issue pushes a 1-bit channel tag into an in-order tag FIFO of depth 2*OBUF_DEPTH; the credit rule guarantees it never overflows.
REQ-018 When fir_out_valid = 1, pop the tag and write fir_out_data into that channel's buffer; credit is unchanged (in-flight decrements, occupancy increments).
REQ-019 If fir_out_valid = 1 with the tag FIFO empty: discard the result, set orphan_err, and leave all buffers unchanged.
REQ-020 Output buffers are show-ahead FIFOs: *_out_valid = not empty, *_out_data = head; a pop on valid AND ready frees one credit in the next cycle.
REQ-021 Push and pop on the same buffer in the same cycle are both honoured; occupancy is unchanged.
REQ-022 Issue and FIR return in the same cycle are both honoured in the tag FIFO.

Reset
REQ-023 While reset_reset = 1 at a clock edge: clear all FIFOs, in-flight counts and sticky flags; set rr_ptr to left.
REQ-024 Output values during and after reset: fir_in_valid=0, fir_in_data=0, *_out_valid=0, *_in_ready=0 while reset is high, orphan_err=0, fir_err=0.
REQ-025 On reset mid-operation, in-flight FIR results arriving after reset are handled as orphans under REQ-019.

Configuration
REQ-026 Macro AUD_FIR_ARB_ERR_EN defined: a FIR result with nonzero fir_out_error is stored as 32'h0 and sets fir_err.
REQ-027 Macro AUD_FIR_ARB_ERR_EN undefined: fir_out_error is ignored, results are stored unmodified, and fir_err is tied to 0.

Structure
REQ-028 Shared package aud_pkg holds: the channel enum (CH_LEFT=0, CH_RIGHT=1), sample widths (32 and 16), and the error-code width (2).
REQ-029 One sub-module, aud_sync_fifo (parameterised width/depth, show-ahead), is instantiated for both output buffers and for the tag FIFO.

Verification
REQ-030 Both channels valid continuously, both outputs ready, FIR model with 5-cycle latency: issues alternate L,R,L,R; each result returns to the correct channel in order.
REQ-031 right_out_ready=0 with OBUF_DEPTH=4: right_in_ready falls after 4 right issues; left traffic continues at full rate.
REQ-032 left_in_data=32'h1234_ABCD with IN_MSB=31: fir_in_data=16'h1234 one cycle after transfer; with IN_MSB=23: 16'h34AB.
REQ-033 fir_out_valid pulsed with no outstanding issue: orphan_err=1 and no *_out_valid asserted.
REQ-034 With AUD_FIR_ARB_ERR_EN defined, fir_out_error=2'b01 on result 32'h0000_0100: output data is 32'h0 and fir_err=1; with the macro undefined, output is 32'h0000_0100 and fir_err=0.
REQ-035 Reset asserted with 3 samples in flight: after release all valids are 0, and the 3 late FIR results set orphan_err.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio types: channel identifiers and sample/error widths.
package aud_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned SLICE_W  = 16;
  localparam int unsigned ERR_W    = 2;

endpackage

// File: rtl/aud_sync_fifo.sv
// Show-ahead synchronous FIFO; head_o is valid whenever empty_o is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module aud_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i & (cnt_q < CNT_W'(DEPTH));
  assign do_pop  = pop_i & (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q + PTR_W'(do_push);
    rd_d  = rd_q + PTR_W'(do_pop);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/aud_fir_arbiter.sv
// Round-robin sharing of one FIR between left/right streams with credit-based
// result buffering. Define AUD_FIR_ARB_ERR_EN to zero and flag errored results.
module aud_fir_arbiter
  import aud_pkg::*;
#(
  parameter int unsigned OBUF_DEPTH = 4,
  parameter int unsigned IN_MSB     = 31
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [SAMPLE_W-1:0] left_in_data,
  input  logic                left_in_valid,
  output logic                left_in_ready,
  input  logic [SAMPLE_W-1:0] right_in_data,
  input  logic                right_in_valid,
  output logic                right_in_ready,
  output logic [SLICE_W-1:0]  fir_in_data,
  output logic                fir_in_valid,
  output logic [ERR_W-1:0]    fir_in_error,
  input  logic [SAMPLE_W-1:0] fir_out_data,
  input  logic                fir_out_valid,
  input  logic [ERR_W-1:0]    fir_out_error,
  output logic [SAMPLE_W-1:0] left_out_data,
  output logic                left_out_valid,
  input  logic                left_out_ready,
  output logic [SAMPLE_W-1:0] right_out_data,
  output logic                right_out_valid,
  input  logic                right_out_ready,
  output logic                orphan_err,
  output logic                fir_err
);

  localparam int unsigned CNT_W     = $clog2(OBUF_DEPTH) + 1;
  localparam int unsigned TAG_DEPTH = 2 * OBUF_DEPTH;
  localparam int unsigned TAG_CNT_W = $clog2(TAG_DEPTH) + 1;

  ch_e                 rr_q, rr_d;
  logic [CNT_W-1:0]    infl_l_q, infl_l_d, infl_r_q, infl_r_d;
  logic [CNT_W-1:0]    occ_l, occ_r;
  logic [CNT_W:0]      used_l, used_r;
  logic                elig_l, elig_r;
  logic                xfer_l, xfer_r, xfer;
  logic [SAMPLE_W-1:0] sel_sample, store_data;
  logic [SLICE_W-1:0]  fir_in_data_q, fir_in_data_d;
  logic                fir_in_valid_q, fir_in_valid_d;
  logic                orphan_q, orphan_d;
  logic                tag_empty;
  logic [0:0]          tag_head;
  logic [TAG_CNT_W-1:0] unused_tag_cnt;
  logic                ret_ok, ret_l, ret_r;
  logic                empty_l, empty_r;
  logic                unused_bits;

  // Credit is exhausted once buffered plus in-flight results reach the depth.
  assign used_l = (CNT_W+1)'(occ_l) + (CNT_W+1)'(infl_l_q);
  assign used_r = (CNT_W+1)'(occ_r) + (CNT_W+1)'(infl_r_q);
  assign elig_l = used_l < (CNT_W+1)'(OBUF_DEPTH);
  assign elig_r = used_r < (CNT_W+1)'(OBUF_DEPTH);

  assign left_in_ready  = ~reset_reset & elig_l &
                          ((rr_q == CH_LEFT) | ~right_in_valid | ~elig_r);
  assign right_in_ready = ~reset_reset & elig_r &
                          ((rr_q == CH_RIGHT) | ~left_in_valid | ~elig_l);

  assign xfer_l     = left_in_valid & left_in_ready;
  assign xfer_r     = right_in_valid & right_in_ready;
  assign xfer       = xfer_l | xfer_r;
  assign sel_sample = xfer_r ? right_in_data : left_in_data;

  // A result with no outstanding tag is an orphan and is dropped.
  assign ret_ok = fir_out_valid & ~tag_empty;
  assign ret_l  = ret_ok & (ch_e'(tag_head) == CH_LEFT);
  assign ret_r  = ret_ok & (ch_e'(tag_head) == CH_RIGHT);

`ifdef AUD_FIR_ARB_ERR_EN
  logic fir_err_q, fir_err_d;

  assign store_data  = (fir_out_error != '0) ? '0 : fir_out_data;
  assign fir_err_d   = fir_err_q | (ret_ok & (fir_out_error != '0));
  assign fir_err     = fir_err_q;
  assign unused_bits = ^sel_sample;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) fir_err_q <= 1'b0;
    else             fir_err_q <= fir_err_d;
  end
`else
  assign store_data  = fir_out_data;
  assign fir_err     = 1'b0;
  assign unused_bits = ^{sel_sample, fir_out_error};
`endif

  always_comb begin
    rr_d           = rr_q;
    fir_in_valid_d = xfer;
    fir_in_data_d  = fir_in_data_q;
    infl_l_d       = infl_l_q + CNT_W'(xfer_l) - CNT_W'(ret_l);
    infl_r_d       = infl_r_q + CNT_W'(xfer_r) - CNT_W'(ret_r);
    orphan_d       = orphan_q | (fir_out_valid & tag_empty);
    if (xfer) begin
      rr_d          = ch_e'(~rr_q);
      fir_in_data_d = sel_sample[IN_MSB -: SLICE_W];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rr_q           <= CH_LEFT;
      fir_in_valid_q <= 1'b0;
      fir_in_data_q  <= '0;
      infl_l_q       <= '0;
      infl_r_q       <= '0;
      orphan_q       <= 1'b0;
    end else begin
      rr_q           <= rr_d;
      fir_in_valid_q <= fir_in_valid_d;
      fir_in_data_q  <= fir_in_data_d;
      infl_l_q       <= infl_l_d;
      infl_r_q       <= infl_r_d;
      orphan_q       <= orphan_d;
    end
  end

  assign fir_in_valid = fir_in_valid_q;
  assign fir_in_data  = fir_in_data_q;
  assign fir_in_error = '0;
  assign orphan_err   = orphan_q;

  // In-order record of which channel each outstanding FIR result belongs to.
  aud_sync_fifo #(.WIDTH(1), .DEPTH(TAG_DEPTH)) u_tag (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .push_i      (xfer),
    .push_data_i (xfer_r),
    .pop_i       (ret_ok),
    .head_o      (tag_head),
    .empty_o     (tag_empty),
    .count_o     (unused_tag_cnt)
  );

  aud_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(OBUF_DEPTH)) u_obuf_l (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .push_i      (ret_l),
    .push_data_i (store_data),
    .pop_i       (left_out_valid & left_out_ready),
    .head_o      (left_out_data),
    .empty_o     (empty_l),
    .count_o     (occ_l)
  );

  aud_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(OBUF_DEPTH)) u_obuf_r (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .push_i      (ret_r),
    .push_data_i (store_data),
    .pop_i       (right_out_valid & right_out_ready),
    .head_o      (right_out_data),
    .empty_o     (empty_r),
    .count_o     (occ_r)
  );

  assign left_out_valid  = ~empty_l;
  assign right_out_valid = ~empty_r;

endmodule
